// File: rtl/conv2d_stream.sv
// -----------------------------------------------------------------------------
// conv2d_stream
//
// Streaming 3x3 convolution engine. Consumes a raster-order unsigned pixel
// stream. For every completed 3x3 window it returns one signed result, so the
// output is the valid-region feature map in raster order.
//
// Datapath:
//   * two IMG_W-deep line buffers hold rows r-1 (lb1) and r-2 (lb2)
//   * a 3x3 window shifts left one column per accepted pixel; the new right
//     column is {lb2 oldest, lb1 oldest, pixel_in}
//   * a 9-tap signed weight bank, row-major, where tap 0 is the top-left
//   * full-precision multiply/accumulate, sign-extended to ACC_W
//
// Handshake: a pixel is accepted on any rising edge where pixel_valid=1.
// There is no backpressure. valid is a one-cycle strobe, registered one cycle
// after the completing pixel, and the consumer must take every strobe.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-low reset
//   pixel_in    pixel data (unsigned, PIX_W), sampled when pixel_valid=1
//   pixel_valid pixel strobe; gaps allowed
//   w_load      weight write strobe (honoured only while IDLE)
//   w_addr      tap index 0..8; 9..15 are ignored
//   w_data      tap value (signed, WGT_W)
//   conv_out    signed convolution result
//   valid       one-cycle strobe qualifying conv_out
//   frame_done  one-cycle pulse coincident with the last valid of a frame
//   busy        high from the first accepted pixel of a frame until frame_done
//
// Build option:
//   CONV2D_RELU_EN  when defined, conv_out = max(sum, 0). valid and
//                   frame_done timing do not change.
// -----------------------------------------------------------------------------
module conv2d_stream #(
    parameter int IMG_W = 5,
    parameter int IMG_H = 5,
    parameter int PIX_W = 8,
    parameter int WGT_W = 8,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             w_load,
    input  logic [3:0]       w_addr,
    input  logic [WGT_W-1:0] w_data,
    output logic [ACC_W-1:0] conv_out,
    output logic             valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    // A zero-extended pixel times a signed weight needs PIX_W+1+WGT_W bits.
    // Nine such products need 4 more bits.
    localparam int SUM_W = PIX_W + WGT_W + 1 + 4;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    // ---------------------------------------------------------------------
    // Frame FSM
    //   IDLE   : nothing of the current frame accepted yet
    //   STREAM : accepting pixels of a frame
    //   DONE   : single cycle after the last pixel. It lines up with the
    //            final registered result. Pixel 0 of the next frame may be
    //            accepted in this cycle.
    // state_q is typed so that a checker can bind to it by name.
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    logic [PIX_W-1:0] lb1_q [IMG_W];
    logic [PIX_W-1:0] lb1_d [IMG_W];
    logic [PIX_W-1:0] lb2_q [IMG_W];
    logic [PIX_W-1:0] lb2_d [IMG_W];

    // Window flattened row-major: index r*3+c, with row 0 = oldest (r-2).
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] win_d [9];

    logic [WGT_W-1:0] wgt_q [9];
    logic [WGT_W-1:0] wgt_d [9];

    logic [ACC_W-1:0] conv_q, conv_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             last_pix;
    logic             win_done;
    logic [SUM_W-1:0] sum;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] result;

    assign accept   = pixel_valid;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    // The window is complete once this pixel fills the third row and the
    // third column.
    assign win_done = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (accept && last_pix) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = accept ? ST_STREAM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        frame_done = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_STREAM: busy = 1'b1;
            ST_DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default: begin
                frame_done = 1'b0;
                busy       = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Weight bank. Writes are accepted only between frames, so a frame never
    // sees a mix of old and new taps. A write in the same cycle as pixel 0 is
    // still in IDLE and therefore lands before the first window completes.
    // ---------------------------------------------------------------------
    always_comb begin
        wgt_d = wgt_q;
        if (w_load && (state_q == ST_IDLE) && (w_addr < 4'd9)) begin
            wgt_d[w_addr] = w_data;
        end
    end

    // ---------------------------------------------------------------------
    // Line buffers and window. Index 0 of a line buffer is the newest entry
    // and index IMG_W-1 is the oldest, which is the same column one row up.
    // ---------------------------------------------------------------------
    always_comb begin
        lb1_d = lb1_q;
        lb2_d = lb2_q;
        win_d = win_q;
        if (accept) begin
            lb1_d[0] = pixel_in;
            lb2_d[0] = lb1_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb1_d[i] = lb1_q[i-1];
                lb2_d[i] = lb2_q[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb2_q[IMG_W-1];
            win_d[5] = lb1_q[IMG_W-1];
            win_d[8] = pixel_in;
        end
    end

    // ---------------------------------------------------------------------
    // Multiply-accumulate on the window as it stands after this pixel.
    // This lets the result be registered on the same edge that accepts the
    // completing pixel.
    // ---------------------------------------------------------------------
    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum
                + ($signed({{(SUM_W-PIX_W){1'b0}}, win_d[k]})
                 * $signed({{(SUM_W-WGT_W){wgt_q[k][WGT_W-1]}}, wgt_q[k]}));
        end
    end

    assign sum_ext = {{(ACC_W-SUM_W){sum[SUM_W-1]}}, sum};

`ifdef CONV2D_RELU_EN
    assign result = sum_ext[ACC_W-1] ? '0 : sum_ext;
`else
    assign result = sum_ext;
`endif

    always_comb begin
        valid_d = win_done;
        conv_d  = win_done ? result : conv_q;
    end

    // ---------------------------------------------------------------------
    // Control and output registers (reset)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q   <= '0;
            row_q   <= '0;
            conv_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            conv_q  <= conv_d;
            valid_q <= valid_d;
        end
    end

    // Identity kernel out of reset: the centre tap is 1 and all others are 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 9; k++) begin
                wgt_q[k] <= (k == 4) ? WGT_W'(1) : '0;
            end
        end else begin
            wgt_q <= wgt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Pixel storage has no reset: no result is produced until row 2 has
    // refilled both line buffers and the window.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        lb1_q <= lb1_d;
        lb2_q <= lb2_d;
        win_q <= win_d;
    end

    assign conv_out = conv_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic        w_load;
    logic [3:0]  w_addr;
    logic [7:0]  w_data;
    logic [31:0] conv_out;
    logic        valid;
    logic        frame_done;
    logic        busy;

    conv2d_stream #(
        .IMG_W(5), .IMG_H(5), .PIX_W(8), .WGT_W(8), .ACC_W(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .w_load     (w_load),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .conv_out   (conv_out),
        .valid      (valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    bit          last_q[$];

    // Hand-computed results for image value = raster index 0..24
    int exp_id[9]   = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    int exp_ones[9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
`ifdef CONV2D_RELU_EN
    int exp_neg[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    int exp_neg[9]  = '{-54, -63, -72, -99, -108, -117, -144, -153, -162};
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(req), $time);
        end
    endtask

    task automatic push_set(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            case (k)
                0:       exp_q.push_back(exp_id[i]);
                1:       exp_q.push_back(exp_ones[i]);
                default: exp_q.push_back(exp_neg[i]);
            endcase
            last_q.push_back(i == 8);
        end
    endtask

    // Raster position model: predicts on which cycles valid must be high.
    int   m_col, m_row;
    logic exp_v;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_col <= 0;
            m_row <= 0;
            exp_v <= 1'b0;
        end else begin
            exp_v <= pixel_valid && (m_row >= 2) && (m_col >= 2);
            if (pixel_valid) begin
                if (m_col == 4) begin
                    m_col <= 0;
                    m_row <= (m_row == 4) ? 0 : m_row + 1;
                end else begin
                    m_col <= m_col + 1;
                end
            end
        end
    end

    // Monitor: samples away from the active edge.
    logic [31:0] mon_e;
    bit          mon_l;
    always @(negedge clk) begin
        if (rst) begin
            if (valid || exp_v) begin
                checks++;
                if (valid !== exp_v) begin
                    errors++;
                    $display("FAIL valid_timing: got %0b expected %0b at %0t", valid, exp_v, $time);
                end
            end
            if (valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0d expected none at %0t", $signed(conv_out), $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = last_q.pop_front();
                    chk("conv_out", conv_out, mon_e);
                    chk("frame_done", {31'd0, frame_done}, {31'd0, mon_l});
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // busy watch across back-to-back frames
    bit busy_watch = 1'b0;
    bit busy_drop  = 1'b0;
    always @(negedge clk) begin
        if (busy_watch && !busy) busy_drop = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [7:0] p, input logic wl, input logic [3:0] wa, input logic [7:0] wd);
        pixel_in    = p;
        pixel_valid = 1'b1;
        w_load      = wl;
        w_addr      = wa;
        w_data      = wd;
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        w_load      = 1'b0;
    endtask

    task automatic load_w(input logic [3:0] a, input logic [7:0] d);
        w_load = 1'b1;
        w_addr = a;
        w_data = d;
        @(posedge clk);
        #1;
        w_load = 1'b0;
    endtask

    // Sends raster indices first..first+n-1 (value = index mod 25).
    // wl_at selects one index that also carries a weight write.
    task automatic send_frame(input int first, input int n, input bit toggle,
                              input int wl_at, input logic [3:0] wa, input logic [7:0] wd);
        for (int i = first; i < first + n; i++) begin
            send_pixel(8'(i % 25), i == wl_at, wa, wd);
            if (toggle) idle(1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b0;
        pixel_in    = '0;
        pixel_valid = 1'b0;
        w_load      = 1'b0;
        w_addr      = '0;
        w_data      = '0;
        #12;
        chk("reset_conv_out", conv_out, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        #6 rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: identity kernel from reset, continuous stream
        push_set(0, 9);
        send_frame(0, 25, 1'b0, -1, 4'd0, 8'd0);
        idle(3);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);

        // 2: all taps = 1; tap 8 written together with pixel 0; an
        //    out-of-range address and a write during STREAM must be ignored
        for (int a = 0; a < 8; a++) load_w(4'(a), 8'd1);
        load_w(4'd12, 8'd7);
        push_set(1, 9);
        send_pixel(8'd0, 1'b1, 4'd8, 8'd1);
        send_frame(1, 24, 1'b0, 10, 4'd4, 8'hFD);
        idle(3);

        // 3: same weights, pixel_valid toggled every other cycle
        push_set(1, 9);
        send_frame(0, 25, 1'b1, -1, 4'd0, 8'd0);
        idle(3);

        // 4: two back-to-back frames, no gap
        push_set(1, 9);
        push_set(1, 9);
        send_pixel(8'd0, 1'b0, 4'd0, 8'd0);
        busy_watch = 1'b1;
        send_frame(1, 49, 1'b0, -1, 4'd0, 8'd0);
        busy_watch = 1'b0;
        chk("busy_between_frames", {31'd0, busy_drop}, 32'd0);
        idle(3);

        // 5: all taps = -1
        for (int a = 0; a < 9; a++) load_w(4'(a), 8'hFF);
        push_set(2, 9);
        send_frame(0, 25, 1'b0, -1, 4'd0, 8'd0);
        idle(3);

        // 6: reset after pixel 13, then a full frame from the reset weights
        push_set(2, 2);
        send_frame(0, 14, 1'b0, -1, 4'd0, 8'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midreset_conv_out", conv_out, 32'd0);
        chk("midreset_valid", {31'd0, valid}, 32'd0);
        chk("midreset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_drained", exp_q.size(), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        push_set(0, 9);
        send_frame(0, 25, 1'b0, -1, 4'd0, 8'd0);
        idle(5);

        chk("results_outstanding", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
